// File: rtl/mux_4_1_rr_arbiter_if.sv
// rtl/mux_4_1_rr_arbiter_if.sv - bundle of requester and consumer signals around the 4:1 round-robin arbiter
//
// Purpose: groups the four requester streams, the forwarded output stream and
// the arbiter status (sel, locked) into one interface.
// Modports:
//   master : arbiter view (drives in_ready, out_valid/out_data/out_last, sel, locked)
//   slave  : environment view (drives in_valid/in_last/d0..d3, out_ready)
interface mux_4_1_rr_arbiter_if #(
   parameter int W = 4
);
   logic [3:0]   in_valid;
   logic [3:0]   in_last;
   logic [W-1:0] d0;
   logic [W-1:0] d1;
   logic [W-1:0] d2;
   logic [W-1:0] d3;
   logic [3:0]   in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         out_ready;
   logic [1:0]   sel;
   logic         locked;

   modport master (
      input  in_valid, in_last, d0, d1, d2, d3, out_ready,
      output in_ready, out_valid, out_data, out_last, sel, locked
   );

   modport slave (
      output in_valid, in_last, d0, d1, d2, d3, out_ready,
      input  in_ready, out_valid, out_data, out_last, sel, locked
   );
endinterface

// File: rtl/mux_4_1_rr_arbiter.sv
// rtl/mux_4_1_rr_arbiter.sv - round-robin burst arbiter driving a shared 4:1 data mux
//
// Purpose: picks one of four valid/data/last requesters, locks the grant for a
// whole burst (until an accepted beat with last=1) and forwards that stream
// combinationally to a single valid/ready output. Grant priority rotates.
// Ports:
//   clk           system clock
//   rst           synchronous active-low reset
//   bus (master)  requester inputs, in_ready, forwarded output stream, sel, locked
//   timeout_pulse one-cycle pulse when a stalled burst is dropped
//                 (present only with MUX_ARB_TIMEOUT_EN)
// Optional feature macro: MUX_ARB_TIMEOUT_EN (idle timeout while locked).
module mux_4_1_rr_arbiter #(
   parameter int W       = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
`ifdef MUX_ARB_TIMEOUT_EN
   output logic                      timeout_pulse,
`endif
   mux_4_1_rr_arbiter_if.master      bus
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [1:0] sel_q, sel_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [1:0] pick;
   logic       found;
   logic       accept;

   logic [W-1:0] d [4];
   assign d[0] = bus.d0;
   assign d[1] = bus.d1;
   assign d[2] = bus.d2;
   assign d[3] = bus.d3;

`ifdef MUX_ARB_TIMEOUT_EN
   logic [7:0] cnt, cnt_nxt;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         sel_q <= 2'd0;
         ptr   <= 2'd0;
`ifdef MUX_ARB_TIMEOUT_EN
         cnt   <= 8'd0;
`endif
      end else begin
         state <= state_nxt;
         sel_q <= sel_nxt;
         ptr   <= ptr_nxt;
`ifdef MUX_ARB_TIMEOUT_EN
         cnt   <= cnt_nxt;
`endif
      end
   end

   // First requesting index starting from ptr, wrapping mod 4.
   always_comb begin
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!found && bus.in_valid[ptr + 2'(k)]) begin
            pick  = ptr + 2'(k);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      sel_nxt       = sel_q;
      ptr_nxt       = ptr;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.in_ready  = 4'b0000;
      accept        = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_nxt       = cnt;
      timeout_pulse = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = BUSY;
               sel_nxt   = pick;
`ifdef MUX_ARB_TIMEOUT_EN
               cnt_nxt   = 8'd0;
`endif
            end
         end
         BUSY: begin
            bus.out_valid = bus.in_valid[sel_q];
            bus.out_last  = bus.in_last[sel_q];
            bus.in_ready  = bus.out_ready ? (4'b0001 << sel_q) : 4'b0000;
            accept        = bus.out_valid && bus.out_ready;
            if (accept && bus.out_last) begin
               state_nxt = IDLE;
               ptr_nxt   = sel_q + 2'd1;
            end
`ifdef MUX_ARB_TIMEOUT_EN
            if (bus.in_valid[sel_q]) begin
               cnt_nxt = 8'd0;
            end else begin
               cnt_nxt = cnt + 8'd1;
               // The cycle the count reaches TIMEOUT drops the grant.
               if (cnt_nxt == 8'(TIMEOUT)) begin
                  timeout_pulse = 1'b1;
                  state_nxt     = IDLE;
                  ptr_nxt       = sel_q + 2'd1;
                  cnt_nxt       = 8'd0;
               end
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.sel      = sel_q;
   assign bus.locked   = (state == BUSY);
   assign bus.out_data = d[sel_q];

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// tb/tb_mux_4_1_rr_arbiter.sv - table-driven bench for the 4:1 round-robin arbiter
module tb_mux_4_1_rr_arbiter;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
`ifdef MUX_ARB_TIMEOUT_EN
   logic timeout_pulse;
`endif

   always #5 clk = ~clk;

   mux_4_1_rr_arbiter_if #(.W(W)) bus ();

   mux_4_1_rr_arbiter #(.W(W), .TIMEOUT(3)) dut (
      .clk           (clk),
      .rst           (rst),
`ifdef MUX_ARB_TIMEOUT_EN
      .timeout_pulse (timeout_pulse),
`endif
      .bus           (bus)
   );

   typedef struct {
      logic       rst;
      logic [3:0] iv;
      logic [3:0] il;
      logic       ordy;
      logic       ev;
      logic [3:0] er;
      logic [1:0] es;
      logic       el;
      logic [3:0] ed;
      logic       elast;
   } vec_t;

   vec_t tbl [30];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step=%0d got=%0h want=%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] iv, input logic [3:0] il, input logic ordy);
      rst           = r;
      bus.in_valid  = iv;
      bus.in_last   = il;
      bus.out_ready = ordy;
   endtask

   task automatic check_out(input int idx, input logic ev, input logic [3:0] er, input logic [1:0] es,
                            input logic el, input logic [3:0] ed, input logic elast);
      chk("out_valid", idx, 32'(bus.out_valid), 32'(ev));
      chk("in_ready",  idx, 32'(bus.in_ready),  32'(er));
      chk("sel",       idx, 32'(bus.sel),       32'(es));
      chk("locked",    idx, 32'(bus.locked),    32'(el));
      chk("out_data",  idx, 32'(bus.out_data),  32'(ed));
      if (ev) chk("out_last", idx, 32'(bus.out_last), 32'(elast));
   endtask

   initial begin
      // rst iv il ordy | out_valid in_ready sel locked out_data out_last
      tbl[0]  = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 4'h1, 1'b0};
      tbl[1]  = '{1'b1, 4'h4, 4'h4, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 4'h1, 1'b0};
      tbl[2]  = '{1'b1, 4'h4, 4'h4, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 4'hA, 1'b1};
      tbl[3]  = '{1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 4'hA, 1'b0};
      tbl[4]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 4'hA, 1'b0};
      tbl[5]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h8, 2'd3, 1'b1, 4'hC, 1'b1};
      tbl[6]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd3, 1'b0, 4'hC, 1'b0};
      tbl[7]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 2'd0, 1'b1, 4'h1, 1'b1};
      tbl[8]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 4'h1, 1'b0};
      tbl[9]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h2, 2'd1, 1'b1, 4'h5, 1'b1};
      tbl[10] = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd1, 1'b0, 4'h5, 1'b0};
      tbl[11] = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 4'hA, 1'b1};
      tbl[12] = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 4'hA, 1'b0};
      tbl[13] = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h8, 2'd3, 1'b1, 4'hC, 1'b1};
      tbl[14] = '{1'b1, 4'h2, 4'h0, 1'b1, 1'b0, 4'h0, 2'd3, 1'b0, 4'hC, 1'b0};
      tbl[15] = '{1'b1, 4'h3, 4'h0, 1'b1, 1'b1, 4'h2, 2'd1, 1'b1, 4'h5, 1'b0};
      tbl[16] = '{1'b1, 4'h3, 4'h0, 1'b1, 1'b1, 4'h2, 2'd1, 1'b1, 4'h5, 1'b0};
      tbl[17] = '{1'b1, 4'h3, 4'h2, 1'b1, 1'b1, 4'h2, 2'd1, 1'b1, 4'h5, 1'b1};
      tbl[18] = '{1'b1, 4'h5, 4'h4, 1'b1, 1'b0, 4'h0, 2'd1, 1'b0, 4'h5, 1'b0};
      tbl[19] = '{1'b1, 4'h5, 4'h0, 1'b0, 1'b1, 4'h0, 2'd2, 1'b1, 4'hA, 1'b0};
      tbl[20] = '{1'b1, 4'h5, 4'h0, 1'b0, 1'b1, 4'h0, 2'd2, 1'b1, 4'hA, 1'b0};
      tbl[21] = '{1'b1, 4'h5, 4'h0, 1'b0, 1'b1, 4'h0, 2'd2, 1'b1, 4'hA, 1'b0};
      tbl[22] = '{1'b1, 4'h5, 4'h0, 1'b0, 1'b1, 4'h0, 2'd2, 1'b1, 4'hA, 1'b0};
      tbl[23] = '{1'b1, 4'h5, 4'h0, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 4'hA, 1'b0};
      tbl[24] = '{1'b1, 4'h5, 4'h4, 1'b1, 1'b1, 4'h4, 2'd2, 1'b1, 4'hA, 1'b1};
      tbl[25] = '{1'b1, 4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 4'hA, 1'b0};
      tbl[26] = '{1'b1, 4'h1, 4'h0, 1'b1, 1'b1, 4'h1, 2'd0, 1'b1, 4'h1, 1'b0};
      tbl[27] = '{1'b1, 4'hE, 4'h0, 1'b1, 1'b0, 4'h1, 2'd0, 1'b1, 4'h1, 1'b0};
      tbl[28] = '{1'b1, 4'hE, 4'h0, 1'b1, 1'b0, 4'h1, 2'd0, 1'b1, 4'h1, 1'b0};
      tbl[29] = '{1'b1, 4'hE, 4'h0, 1'b1, 1'b0, 4'h1, 2'd0, 1'b1, 4'h1, 1'b0};

      bus.d0 = 4'h1;
      bus.d1 = 4'h5;
      bus.d2 = 4'hA;
      bus.d3 = 4'hC;
      drive(1'b0, 4'h0, 4'h0, 1'b1);
      repeat (2) @(posedge clk);

      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].iv, tbl[i].il, tbl[i].ordy);
         #1;
         check_out(i, tbl[i].ev, tbl[i].er, tbl[i].es, tbl[i].el, tbl[i].ed, tbl[i].elast);
`ifdef MUX_ARB_TIMEOUT_EN
         chk("timeout_pulse", i, 32'(timeout_pulse), 32'(i == 29));
`endif
      end

`ifdef MUX_ARB_TIMEOUT_EN
      // Third bubble cycle timed out: back in IDLE, ptr moved to 1.
      @(negedge clk);
      drive(1'b1, 4'hF, 4'h0, 1'b1);
      #1;
      check_out(100, 1'b0, 4'h0, 2'd0, 1'b0, 4'h1, 1'b0);
      chk("timeout_pulse", 100, 32'(timeout_pulse), 32'd0);
`else
      // Grant still held through a fourth bubble cycle, then burst completes.
      @(negedge clk);
      drive(1'b1, 4'h0, 4'h0, 1'b1);
      #1;
      check_out(100, 1'b0, 4'h1, 2'd0, 1'b1, 4'h1, 1'b0);
      @(negedge clk);
      drive(1'b1, 4'h1, 4'h1, 1'b1);
      #1;
      check_out(101, 1'b1, 4'h1, 2'd0, 1'b1, 4'h1, 1'b1);
      @(negedge clk);
      drive(1'b1, 4'hF, 4'h0, 1'b1);
      #1;
      check_out(102, 1'b0, 4'h0, 2'd0, 1'b0, 4'h1, 1'b0);
`endif

      // Both builds: ptr=1, so requester 1 wins; then reset mid-burst.
      @(negedge clk);
      drive(1'b1, 4'hF, 4'h0, 1'b1);
      #1;
      check_out(110, 1'b1, 4'h2, 2'd1, 1'b1, 4'h5, 1'b0);
      @(negedge clk);
      drive(1'b0, 4'hF, 4'h0, 1'b1);
      #1;
      check_out(111, 1'b1, 4'h2, 2'd1, 1'b1, 4'h5, 1'b0);
      @(negedge clk);
      drive(1'b1, 4'hF, 4'h1, 1'b1);
      #1;
      check_out(112, 1'b0, 4'h0, 2'd0, 1'b0, 4'h1, 1'b0);
      @(negedge clk);
      #1;
      check_out(113, 1'b1, 4'h1, 2'd0, 1'b1, 4'h1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
